// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer : 2-flop sync + whole-vector debounce with change/press strobes
// Optional macro KEY_DEBOUNCE_GLITCH_CNT_EN adds a saturating abort counter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int KEYS            = 25
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [KEYS-1:0] i_gpi,
  output logic [KEYS-1:0] o_keys,
  output logic            o_change,
  output logic [KEYS-1:0] o_press,
  output logic [15:0]     o_glitch_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [KEYS-1:0] s1_q, s2_q;
  logic [KEYS-1:0] cand_q, cand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KEYS-1:0] keys_q, keys_d;
  logic            change_q, change_d;
  logic [KEYS-1:0] press_q, press_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      state_q  <= ST_STABLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      keys_q   <= '0;
      change_q <= 1'b0;
      press_q  <= '0;
    end else begin
      s1_q     <= i_gpi;
      s2_q     <= s1_q;
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      keys_q   <= keys_d;
      change_q <= change_d;
      press_q  <= press_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    keys_d   = keys_q;
    change_d = 1'b0;
    press_d  = '0;
    case (state_q)
      ST_STABLE: begin
        if (s2_q != cand_q) begin
          cand_d  = s2_q;
          cnt_d   = '0;
          state_d = ST_SETTLING;
        end
      end
      ST_SETTLING: begin
        // Any movement restarts the window, so abort always beats commit.
        if (s2_q != cand_q) begin
          cand_d = s2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          keys_d   = cand_q;
          state_d  = ST_STABLE;
          change_d = (cand_q != keys_q);
          press_d  = cand_q & ~keys_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_STABLE;
    endcase
  end

  assign o_keys   = keys_q;
  assign o_change = change_q;
  assign o_press  = press_q;

`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
  logic        glitch_abort;
  logic [15:0] glitch_q;

  assign glitch_abort = (state_q == ST_SETTLING) && (s2_q != cand_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      glitch_q <= '0;
    end else if (glitch_abort && (glitch_q != 16'hFFFF)) begin
      glitch_q <= glitch_q + 16'd1;
    end
  end

  assign o_glitch_cnt = glitch_q;
`else
  assign o_glitch_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_debouncer.sv
// Testbench for key_debouncer with DEBOUNCE_CYCLES=4, KEYS=25.
// Vector table covers press/release/spike/chord; hand sequences cover reset and saturation.
`default_nettype none

module tb_key_debouncer;

  localparam int KEYS = 25;

`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
  localparam bit GON = 1'b1;
`else
  localparam bit GON = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [KEYS-1:0] gpi;
  logic [KEYS-1:0] keys;
  logic            change;
  logic [KEYS-1:0] press;
  logic [15:0]     glitch;

  int errors = 0;
  int checks = 0;

  key_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .KEYS           (KEYS)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_gpi       (gpi),
    .o_keys      (keys),
    .o_change    (change),
    .o_press     (press),
    .o_glitch_cnt(glitch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [KEYS-1:0] gpi;
    logic [KEYS-1:0] keys;
    logic            chg;
    logic [KEYS-1:0] press;
    logic [15:0]     glitch;  // value expected when the counter is built in
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [KEYS-1:0] g, input logic [KEYS-1:0] k,
                              input logic c, input logic [KEYS-1:0] p,
                              input logic [15:0] gl);
    vec_t v;
    v.gpi = g; v.keys = k; v.chg = c; v.press = p; v.glitch = gl;
    tbl.push_back(v);
  endfunction

  function automatic logic [15:0] gexp(input logic [15:0] gl);
    return GON ? gl : 16'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [KEYS-1:0] k, input logic c,
                           input logic [KEYS-1:0] p, input logic [15:0] gl);
    check({tag, ".keys"},   32'(keys),   32'(k));
    check({tag, ".change"}, 32'(change), 32'(c));
    check({tag, ".press"},  32'(press),  32'(p));
    check({tag, ".glitch"}, 32'(glitch), 32'(gexp(gl)));
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Clean press of bit 19: commit visible after edge 7.
    for (int i = 0; i < 6; i++) add(25'h080000, 25'h000000, 1'b0, 25'h0, 16'd0);
    add(25'h080000, 25'h080000, 1'b1, 25'h080000, 16'd0);
    add(25'h080000, 25'h080000, 1'b0, 25'h0, 16'd0);
    // Release back to 0.
    for (int i = 0; i < 6; i++) add(25'h000000, 25'h080000, 1'b0, 25'h0, 16'd0);
    add(25'h000000, 25'h000000, 1'b1, 25'h0, 16'd0);
    add(25'h000000, 25'h000000, 1'b0, 25'h0, 16'd0);
    // One-cycle spike: aborted at edge 4, silent no-change commit at edge 8.
    add(25'h000080, 25'h0, 1'b0, 25'h0, 16'd0);
    for (int i = 0; i < 2; i++) add(25'h000000, 25'h0, 1'b0, 25'h0, 16'd0);
    for (int i = 0; i < 6; i++) add(25'h000000, 25'h0, 1'b0, 25'h0, 16'd1);
    // Chord with skew: bit 12, then bit 0 two cycles later; abort at edge 5.
    for (int i = 0; i < 2; i++) add(25'h001000, 25'h0, 1'b0, 25'h0, 16'd1);
    for (int i = 0; i < 2; i++) add(25'h001001, 25'h0, 1'b0, 25'h0, 16'd1);
    for (int i = 0; i < 4; i++) add(25'h001001, 25'h0, 1'b0, 25'h0, 16'd2);
    add(25'h001001, 25'h001001, 1'b1, 25'h001001, 16'd2);
    add(25'h001001, 25'h001001, 1'b0, 25'h0, 16'd2);
    // Move chord to bit 14: only bit 14 is a new press.
    for (int i = 0; i < 6; i++) add(25'h004000, 25'h001001, 1'b0, 25'h0, 16'd2);
    add(25'h004000, 25'h004000, 1'b1, 25'h004000, 16'd2);
    add(25'h004000, 25'h004000, 1'b0, 25'h0, 16'd2);
    // Release from 25'h004000: change pulse with empty press mask.
    for (int i = 0; i < 6; i++) add(25'h000000, 25'h004000, 1'b0, 25'h0, 16'd2);
    add(25'h000000, 25'h000000, 1'b1, 25'h0, 16'd2);
    add(25'h000000, 25'h000000, 1'b0, 25'h0, 16'd2);

    rst = 1'b1;
    gpi = '0;
    edges(2);
    check_all("reset", 25'h0, 1'b0, 25'h0, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      gpi = tbl[i].gpi;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].keys, tbl[i].chg, tbl[i].press, tbl[i].glitch);
    end

    // Commit a value, then assert reset asynchronously in the middle of a settle window.
    gpi = 25'h1F00000;
    edges(8);
    check_all("pre_rst_commit", 25'h1F00000, 1'b0, 25'h0, 16'd2);
    gpi = 25'h0000003;
    edges(3);
    gpi = 25'h0000005;
    edges(3);
    #3;
    rst = 1'b1;
    #1;
    check_all("async_rst", 25'h0, 1'b0, 25'h0, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    edges(6);
    check_all("post_rst_e6", 25'h0, 1'b0, 25'h0, 16'd0);
    edges(1);
    check_all("post_rst_e7", 25'h0000005, 1'b1, 25'h0000005, 16'd0);

`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    // Alternating bits keep every cycle an abort; the counter must stop at FFFF.
    for (int i = 0; i < 70000; i++) begin
      gpi = i[0] ? 25'h0000001 : 25'h0000002;
      @(posedge clk);
    end
    #1;
    check("glitch_sat", 32'(glitch), 32'h0000FFFF);
    check("sat_keys_hold", 32'(keys), 32'h0000005);
    for (int i = 0; i < 10; i++) begin
      gpi = i[0] ? 25'h0000002 : 25'h0000001;
      @(posedge clk);
    end
    #1;
    check("glitch_sat_hold", 32'(glitch), 32'h0000FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
